// File: rtl/wfg_pat_seq.sv
// Pattern sequencer for the waveform generator. It produces the sync and subcycle
// pulses plus the subcycle index that the pattern drivers consume, for bursts or continuous runs.
module wfg_pat_seq #(
  parameter int CNTW   = 16,
  parameter int BURSTW = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ctrl_en_i,
  input  logic              ctrl_start_i,
  input  logic              ctrl_stop_i,
  input  logic [CNTW-1:0]   cfg_subcycle_i,
  input  logic [7:0]        cfg_sync_i,
  input  logic [BURSTW-1:0] cfg_burst_i,
  output logic              wfg_pat_sync_o,
  output logic              wfg_pat_subcycle_o,
  output logic [7:0]        wfg_pat_subcycle_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [BURSTW-1:0] run_cnt_o
);

  // state | meaning
  // IDLE  | waiting for start; pulses and subcycle index held at 0
  // RUN   | prescaler and subcycle counter advancing from latched config
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   presc_q, p_q;
  logic [7:0]        sub_q, s_q;
  logic [BURSTW-1:0] b_q, run_cnt_q, run_cnt_inc;
  logic              done_q;

  logic running, start_ok, abort, tick, sync_end, burst_end;

  assign running     = (state_q == RUN);
  assign start_ok    = ctrl_start_i & ctrl_en_i & ~ctrl_stop_i;
  assign abort       = running & (ctrl_stop_i | ~ctrl_en_i);
  assign tick        = running & (presc_q == p_q);
  assign sync_end    = tick & (sub_q == s_q);
  assign run_cnt_inc = run_cnt_q + BURSTW'(1);
  assign burst_end   = sync_end & (b_q != '0) & (run_cnt_inc == b_q);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Abort and burst end both return to IDLE; only burst end raises done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (abort || burst_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      presc_q   <= '0;
      sub_q     <= '0;
      run_cnt_q <= '0;
      p_q       <= '0;
      s_q       <= '0;
      b_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!running) begin
        if (start_ok) begin
          p_q       <= cfg_subcycle_i;
          s_q       <= cfg_sync_i;
          b_q       <= cfg_burst_i;
          presc_q   <= '0;
          sub_q     <= '0;
          run_cnt_q <= '0;
        end
      end else if (!abort) begin
        if (tick) begin
          presc_q <= '0;
          sub_q   <= (sub_q == s_q) ? 8'd0 : sub_q + 8'd1;
          if (sync_end)  run_cnt_q <= run_cnt_inc;
          if (burst_end) done_q    <= 1'b1;
        end else begin
          presc_q <= presc_q + CNTW'(1);
        end
      end
    end
  end

  assign busy_o                 = running;
  assign wfg_pat_subcycle_o     = running & (presc_q == '0);
  assign wfg_pat_sync_o         = wfg_pat_subcycle_o & (sub_q == 8'd0);
  assign wfg_pat_subcycle_cnt_o = running ? sub_q : 8'd0;
  assign done_o                 = done_q;
  assign run_cnt_o              = run_cnt_q;

endmodule

// File: tb/tb_wfg_pat_seq.sv
// Bench for wfg_pat_seq: directed scenarios followed by random control/config traffic,
// with every cycle compared against an arithmetic model of elapsed run time.
module tb_wfg_pat_seq;
  localparam int CNTW   = 16;
  localparam int BURSTW = 16;

  logic              clk = 1'b0;
  logic              rst, en, start, stop;
  logic [CNTW-1:0]   cfg_p;
  logic [7:0]        cfg_s;
  logic [BURSTW-1:0] cfg_b;
  logic              sync_o, sub_o, busy_o, done_o;
  logic [7:0]        cnt_o;
  logic [BURSTW-1:0] run_cnt_o;

  int total = 0;
  int bad   = 0;

  // Model: elapsed RUN cycles since start plus latched P/S/B.
  bit     m_run  = 1'b0;
  bit     m_done = 1'b0;
  longint m_k = 0, m_p = 0, m_s = 0, m_b = 0, m_cnt = 0;

  wfg_pat_seq #(.CNTW(CNTW), .BURSTW(BURSTW)) dut (
    .wb_clk_i               (clk),
    .wb_rst_i               (rst),
    .ctrl_en_i              (en),
    .ctrl_start_i           (start),
    .ctrl_stop_i            (stop),
    .cfg_subcycle_i         (cfg_p),
    .cfg_sync_i             (cfg_s),
    .cfg_burst_i            (cfg_b),
    .wfg_pat_sync_o         (sync_o),
    .wfg_pat_subcycle_o     (sub_o),
    .wfg_pat_subcycle_cnt_o (cnt_o),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .run_cnt_o              (run_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    longint per;
    if (m_run) begin
      per = (m_s + 1) * (m_p + 1);
      check("busy",     64'(busy_o),    64'd1);
      check("subpulse", 64'(sub_o),     ((m_k % (m_p + 1)) == 0) ? 64'd1 : 64'd0);
      check("sync",     64'(sync_o),    ((m_k % per) == 0) ? 64'd1 : 64'd0);
      check("subcnt",   64'(cnt_o),     64'((m_k / (m_p + 1)) % (m_s + 1)));
      check("run_cnt",  64'(run_cnt_o), 64'((m_k / per) % 65536));
      check("done",     64'(done_o),    64'd0);
    end else begin
      check("busy",     64'(busy_o),    64'd0);
      check("subpulse", 64'(sub_o),     64'd0);
      check("sync",     64'(sync_o),    64'd0);
      check("subcnt",   64'(cnt_o),     64'd0);
      check("run_cnt",  64'(run_cnt_o), 64'(m_cnt));
      check("done",     64'(done_o),    64'(m_done));
    end
  endtask

  task automatic model_step();
    longint per;
    if (rst) begin
      m_run = 0; m_done = 0; m_k = 0; m_cnt = 0; m_p = 0; m_s = 0; m_b = 0;
    end else if (!m_run) begin
      m_done = 0;
      if (start && en && !stop) begin
        m_run = 1; m_k = 0; m_cnt = 0;
        m_p = longint'(cfg_p); m_s = longint'(cfg_s); m_b = longint'(cfg_b);
      end
    end else begin
      per = (m_s + 1) * (m_p + 1);
      if (stop || !en) begin
        m_run = 0;
        m_cnt = (m_k / per) % 65536;
      end else begin
        m_k++;
        if (m_b != 0 && m_k == m_b * per) begin
          m_run = 0; m_done = 1; m_cnt = m_b;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit st, input bit sp,
                     input int p, input int s, input int b);
    rst = r; en = e; start = st; stop = sp;
    cfg_p = CNTW'(p); cfg_s = 8'(s); cfg_b = BURSTW'(b);
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_p = '0; cfg_s = '0; cfg_b = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Burst P=0 S=3 B=2
    cyc(0, 1, 1, 0, 0, 3, 2);
    repeat (11) cyc(0, 1, 0, 0, 0, 3, 2);

    // Continuous P=2 S=1, stopped after 20 RUN cycles
    cyc(0, 1, 1, 0, 2, 1, 0);
    repeat (19) cyc(0, 1, 0, 0, 2, 1, 0);
    cyc(0, 1, 0, 1, 2, 1, 0);
    repeat (3) cyc(0, 1, 0, 0, 2, 1, 0);

    // Config changes mid-run are ignored
    cyc(0, 1, 1, 0, 1, 1, 3);
    repeat (2) cyc(0, 1, 0, 0, 1, 1, 3);
    repeat (14) cyc(0, 1, 0, 0, 5, 7, 1);

    // Rejected starts, then start pulses inside a run
    repeat (3) cyc(0, 0, 1, 0, 1, 1, 1);
    repeat (3) cyc(0, 1, 1, 1, 1, 1, 1);
    cyc(0, 1, 1, 0, 1, 2, 2);
    repeat (4) begin
      cyc(0, 1, 0, 0, 1, 2, 2);
      cyc(0, 1, 1, 0, 1, 2, 2);
    end

    // Reset mid-run, then single-cycle burst
    cyc(0, 1, 1, 0, 3, 3, 0);
    repeat (5) cyc(0, 1, 0, 0, 3, 3, 0);
    cyc(1, 1, 0, 0, 3, 3, 0);
    cyc(0, 1, 1, 0, 0, 0, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 1);

    // Stop on the final tick of a burst
    cyc(0, 1, 1, 0, 0, 0, 3);
    repeat (2) cyc(0, 1, 0, 0, 0, 0, 3);
    cyc(0, 1, 0, 1, 0, 0, 3);
    repeat (2) cyc(0, 1, 0, 0, 0, 0, 3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 29) != 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 49) == 0),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wfg_pat_seq.md
# wfg_pat_seq

Sequencer that schedules the pattern driver in the waveform generator. It turns start/stop/enable controls and a timing configuration into the per-cycle synchronisation pulse and 8-bit subcycle count consumed by `wfg_drive_pat`. Each run lasts either a programmed number of sync cycles (burst) or continues until stopped. The block sits between the control register block and one or more pattern drivers, all in the Wishbone clock domain.

## Interface

- `CNTW`, default 16: width of the subcycle prescaler.
- `BURSTW`, default 16: width of the burst length and run counter.

- `wb_clk_i`  in  1  system clock; all logic is on the rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `ctrl_en_i`  in  1  global enable; low forces an abort.
- `ctrl_start_i`  in  1  start request, sampled each cycle.
- `ctrl_stop_i`  in  1  abort request, sampled each cycle.
- `cfg_subcycle_i`  in  CNTW  clocks per subcycle minus 1 (P).
- `cfg_sync_i`  in  8  subcycles per sync cycle minus 1 (S).
- `cfg_burst_i`  in  BURSTW  sync cycles per run (B); 0 means continuous.
- `wfg_pat_sync_o`  out  1  one-clock pulse at the start of each sync cycle.
- `wfg_pat_subcycle_o`  out  1  one-clock pulse at the start of each subcycle.
- `wfg_pat_subcycle_cnt_o`  out  8  current subcycle index, 0..S.
- `busy_o`  out  1  high while in RUN.
- `done_o`  out  1  one-clock pulse when a burst completes.
- `run_cnt_o`  out  BURSTW  number of completed sync cycles in the current or last run.

## Operation

- FSM has two states, IDLE and RUN. Reset puts it in IDLE.
- IDLE to RUN: `ctrl_start_i & ctrl_en_i & ~ctrl_stop_i`.
  - On that edge, P, S and B are latched into shadow registers. Config input changes during a run have no effect.
  - The prescaler, subcycle counter and `run_cnt_o` are cleared.
- In RUN, the prescaler counts 0..P. A tick occurs in the cycle where prescaler == P; the prescaler then wraps to 0.
- On a tick, the subcycle count increments, wrapping from S to 0.
- End of sync cycle: a tick while subcycle count == S. On that event, `run_cnt_o` increments (wraps modulo 2^BURSTW in continuous mode).
- Burst end: an end-of-sync-cycle event with B != 0 and `run_cnt_o` + 1 == B.
  - Next state is IDLE.
  - `done_o` pulses in the first IDLE cycle.
  - `run_cnt_o` holds B.
- Abort: `ctrl_stop_i` or `~ctrl_en_i` sampled high in RUN.
  - Next state is IDLE. `done_o` is not asserted.
  - `run_cnt_o` holds its count.
  - Abort takes priority over burst end on the same edge.
- Pulse decoding (from registered state only; no combinational path from any input):
  - `wfg_pat_subcycle_o` = RUN & prescaler == 0.
  - `wfg_pat_sync_o` = RUN & prescaler == 0 & subcycle count == 0.
- `ctrl_start_i` in RUN is ignored; a run is never restarted.
- In IDLE, `wfg_pat_subcycle_cnt_o` = 0 and both pulse outputs are 0.

## Timing

- Reset values: every output is 0; state is IDLE; all counters and shadow registers are 0.
- Start accepted at edge N: `busy_o`, `wfg_pat_sync_o` and `wfg_pat_subcycle_o` are all high in cycle N+1.
- Subcycle pulse period is P+1 clocks; sync pulse period is (S+1)·(P+1) clocks.
- A burst occupies exactly B·(S+1)·(P+1) cycles with `busy_o` high. `done_o` follows in the next cycle, together with `busy_o` low.
- Abort seen at edge M: `busy_o` is low in cycle M+1.
- A new start is accepted in the same cycle that `done_o` is high.
- Reset asserted mid-run: all outputs and state are at reset values in the following cycle.
- Degenerate case P = 0, S = 0: sync and subcycle pulses stay high for every RUN cycle.

## Test plan

- P=0, S=3, B=2, start at cycle 0:
  - Sync high at cycles 1 and 5; subcycle pulse high in cycles 1..8.
  - `wfg_pat_subcycle_cnt_o` = 0,1,2,3,0,1,2,3.
  - `busy_o` high in cycles 1..8; `done_o` high at cycle 9; `run_cnt_o` = 2.
- P=2, S=1, B=0:
  - Subcycle pulse every 3 clocks, sync every 6 clocks, count alternating 0/1.
  - Stop at cycle 20 gives `busy_o` = 0 at cycle 21, no `done_o`, and `run_cnt_o` = 3.
- P=1, S=1, B=3: change config to P=5, S=7, B=1 at cycle 3. Timing stays at period 4, and `done_o` occurs at cycle 13.
- Start held with `ctrl_en_i` = 0 stays IDLE. Start and stop in the same cycle stays IDLE. Start pulsed again during RUN gives no counter restart.
- Assert `wb_rst_i` for one cycle mid-run:
  - The next cycle shows all outputs 0.
  - A subsequent start with P=0, S=0, B=1 gives one cycle of sync plus subcycle with count 0, then `done_o`.
- B=3 with stop asserted on the final tick edge: abort wins, with no `done_o` and `run_cnt_o` = 2.
